// File: rtl/instr_encoder.sv
// RISC-V instruction encoder: packs decoded fields and a signed immediate into I/S/B/R words.
// Latency 1 cycle through a one-deep output register; sustains 1 word/cycle while OutReady is high.
// Backpressure: InReady drops while the output word is held (OutValid && !OutReady) or Flush is high.
// Optional immediate range checking (ImmErr/ErrSticky) is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    IMM_SRC_WIDTH = 2,
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [IMM_SRC_WIDTH-1:0] ImmSrc,
  input  logic [DATA_WIDTH-1:0]    Imm,
  input  logic [6:0]               Opcode,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [4:0]               Rd,
  input  logic [4:0]               Rs1,
  input  logic [4:0]               Rs2,
  input  logic                     Flush,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_WIDTH-1:0]    OutInstr,
  output logic [ADDR_WIDTH-1:0]    OutPc,
  output logic                     ImmErr,
  output logic                     ErrSticky,
  input  logic                     ErrClr
);

  localparam logic [IMM_SRC_WIDTH-1:0] FMT_I = IMM_SRC_WIDTH'(0);
  localparam logic [IMM_SRC_WIDTH-1:0] FMT_S = IMM_SRC_WIDTH'(1);
  localparam logic [IMM_SRC_WIDTH-1:0] FMT_B = IMM_SRC_WIDTH'(2);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [DATA_WIDTH-1:0]   instr_d;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   next_pc_q;
  logic                    accept;

  // A new word may enter when the output slot is free or is being drained this cycle.
  assign InReady  = rst_n & ~Flush & ((state_q == EMPTY) | OutReady);
  assign accept   = InValid & InReady;
  assign OutValid = (state_q == FULL);
  assign OutInstr = instr_q;
  assign OutPc    = pc_q;

  // Field packing; immediate bits beyond each format's field are simply truncated.
  always_comb begin
    instr_d        = '0;
    instr_d[6:0]   = Opcode;
    instr_d[14:12] = Funct3;
    instr_d[19:15] = Rs1;
    case (ImmSrc)
      FMT_I: begin
        instr_d[31:20] = Imm[11:0];
        instr_d[11:7]  = Rd;
      end
      FMT_S: begin
        instr_d[31:25] = Imm[11:5];
        instr_d[24:20] = Rs2;
        instr_d[11:7]  = Imm[4:0];
      end
      FMT_B: begin
        instr_d[31]    = Imm[12];
        instr_d[30:25] = Imm[10:5];
        instr_d[24:20] = Rs2;
        instr_d[11:8]  = Imm[4:1];
        instr_d[7]     = Imm[11];
      end
      default: begin
        instr_d[31:25] = Funct7;
        instr_d[24:20] = Rs2;
        instr_d[11:7]  = Rd;
      end
    endcase
  end

  // Output slot FSM: Flush beats accept, accept beats drain; the word is held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      instr_q   <= '0;
      pc_q      <= BASE_ADDR;
      next_pc_q <= BASE_ADDR;
    end else if (Flush) begin
      state_q   <= EMPTY;
      next_pc_q <= BASE_ADDR;
    end else if (accept) begin
      state_q   <= FULL;
      instr_q   <= instr_d;
      pc_q      <= next_pc_q;
      next_pc_q <= next_pc_q + ADDR_WIDTH'(4);
    end else if (OutReady) begin
      state_q   <= EMPTY;
    end
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic imm_err_d;
  logic err_q;
  logic sticky_q;
  logic fits12;
  logic fits13;

  // Upper bits must be pure sign extension of the field's top bit.
  assign fits12 = (&Imm[DATA_WIDTH-1:11]) | ~(|Imm[DATA_WIDTH-1:11]);
  assign fits13 = (&Imm[DATA_WIDTH-1:12]) | ~(|Imm[DATA_WIDTH-1:12]);

  // Per-format range test; branch offsets must also be halfword aligned.
  always_comb begin
    imm_err_d = 1'b0;
    case (ImmSrc)
      FMT_I, FMT_S: imm_err_d = ~fits12;
      FMT_B:        imm_err_d = ~fits13 | Imm[0];
      default:      imm_err_d = 1'b0;
    endcase
  end

  // Error flag travels with the word it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= imm_err_d;
    end
  end

  // Sticky error: a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (accept && imm_err_d) begin
      sticky_q <= 1'b1;
    end else if (ErrClr) begin
      sticky_q <= 1'b0;
    end
  end

  assign ImmErr    = err_q;
  assign ErrSticky = sticky_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{ErrClr, Imm[DATA_WIDTH-1:13]};
  assign ImmErr        = 1'b0;
  assign ErrSticky     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors, backpressure, flush, reset, then random traffic.
// Expected words come from arithmetic field packing and signed range tests, queued at acceptance.
// A forked monitor compares every cycle on the falling clock edge and pops when the consumer drains.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [1:0]  ImmSrc = '0;
  logic [31:0] Imm = '0;
  logic [6:0]  Opcode = '0;
  logic [2:0]  Funct3 = '0;
  logic [6:0]  Funct7 = '0;
  logic [4:0]  Rd = '0;
  logic [4:0]  Rs1 = '0;
  logic [4:0]  Rs2 = '0;
  logic        Flush = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] OutInstr;
  logic [31:0] OutPc;
  logic        ImmErr;
  logic        ErrSticky;
  logic        ErrClr = 1'b0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .ImmSrc(ImmSrc), .Imm(Imm), .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
    .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .OutInstr(OutInstr), .OutPc(OutPc),
    .ImmErr(ImmErr), .ErrSticky(ErrSticky), .ErrClr(ErrClr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] pc_m = BASE;
  logic        sticky_m = 1'b0;
  bit          rand_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference packing written as shifts and masks over the immediate's integer value.
  function automatic logic [31:0] enc(input int src, input int imm, input int op, input int f3,
                                      input int f7, input int rd, input int rs1, input int rs2);
    logic [31:0] u;
    logic [31:0] w;
    u = imm;
    w = op | (f3 << 12) | (rs1 << 15);
    case (src)
      0: w = w | ((u & 32'hFFF) << 20) | (rd << 7);
      1: w = w | (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | ((u & 32'h1F) << 7);
      2: w = w | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
               | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
      default: w = w | (f7 << 25) | (rs2 << 20) | (rd << 7);
    endcase
    return w;
  endfunction

  function automatic logic range_err(input int src, input int imm);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    case (src)
      0, 1: return (imm < -2048) || (imm > 2047);
      2:    return (imm < -4096) || (imm > 4095) || ((imm & 1) != 0);
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // Present one request and hold it until the DUT takes it (bounded).
  task automatic send(input int src, input int imm, input int op, input int f3, input int f7,
                      input int rd, input int rs1, input int rs2);
    bit taken;
    ImmSrc = 2'(src); Imm = imm; Opcode = 7'(op); Funct3 = 3'(f3); Funct7 = 7'(f7);
    Rd = 5'(rd); Rs1 = 5'(rs1); Rs2 = 5'(rs2);
    InValid = 1'b1;
    taken = 1'b0;
    for (int t = 0; t < 200 && !taken; t++) begin
      @(negedge clk);
      taken = InReady;
      @(posedge clk);
      #1;
    end
    InValid = 1'b0;
    if (!taken) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: request never accepted, got no accept expected accept");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      // Monitor / scoreboard.
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk("rst_outvalid", 32'(OutValid), 32'h0);
          chk("rst_outinstr", OutInstr, 32'h0);
          chk("rst_outpc", OutPc, BASE);
          chk("rst_immerr", 32'(ImmErr), 32'h0);
          chk("rst_sticky", 32'(ErrSticky), 32'h0);
          chk("rst_inready", 32'(InReady), 32'h0);
          q.delete();
          pc_m = BASE;
          sticky_m = 1'b0;
        end else begin
          logic exp_rdy;
          logic acc;
          exp_rdy = !Flush && (q.size() == 0 || OutReady);
          acc = InValid && exp_rdy;
          chk("outvalid", 32'(OutValid), 32'(q.size() != 0));
          chk("inready", 32'(InReady), 32'(exp_rdy));
          chk("sticky", 32'(ErrSticky), 32'(sticky_m));
          if (OutValid && q.size() != 0) begin
            chk("instr", OutInstr, q[0].instr);
            chk("pc", OutPc, q[0].pc);
            chk("immerr", 32'(ImmErr), 32'(q[0].err));
          end
          if (Flush) begin
            q.delete();
            pc_m = BASE;
            if (ErrClr) sticky_m = 1'b0;
          end else begin
            exp_t e;
            if (q.size() != 0 && OutReady) void'(q.pop_front());
            if (acc) begin
              e.instr = enc(int'(ImmSrc), int'(Imm), int'(Opcode), int'(Funct3), int'(Funct7),
                            int'(Rd), int'(Rs1), int'(Rs2));
              e.pc = pc_m;
              e.err = range_err(int'(ImmSrc), int'(Imm));
              q.push_back(e);
              pc_m = pc_m + 32'd4;
            end
            if (acc && e.err) sticky_m = 1'b1;
            else if (ErrClr) sticky_m = 1'b0;
          end
        end
      end
    join_none

    // Reset.
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    OutReady = 1'b1;
    idle(1);

    // Directed encodings (I, S, B, B misaligned, I out of range).
    send(0, 5, 'h13, 0, 0, 1, 0, 0);
    send(1, 8, 'h23, 2, 0, 0, 1, 2);
    send(2, -4, 'h63, 0, 0, 0, 1, 2);
    send(2, 3, 'h63, 0, 0, 0, 1, 2);
    send(0, 2048, 'h13, 0, 0, 3, 4, 0);
    send(3, 123, 'h33, 0, 'h20, 5, 6, 7);
    send(1, -2049, 'h23, 1, 0, 0, 8, 9);
    send(2, 4094, 'h63, 1, 0, 0, 10, 11);
    idle(3);
    ErrClr = 1'b1;
    idle(1);
    ErrClr = 1'b0;
    // Error and clear in the same cycle: error must win.
    ErrClr = 1'b1;
    send(0, -5000, 'h13, 0, 0, 1, 1, 0);
    ErrClr = 1'b0;
    idle(2);

    // Backpressure after restarting the address at BASE.
    Flush = 1'b1;
    idle(1);
    Flush = 1'b0;
    OutReady = 1'b0;
    send(0, 1, 'h13, 0, 0, 1, 2, 0);
    fork
      send(0, 2, 'h13, 0, 0, 3, 4, 0);
      begin
        idle(3);
        OutReady = 1'b1;
      end
    join
    send(0, 3, 'h13, 0, 0, 5, 6, 0);
    idle(2);

    // Flush with a held word and a pending request.
    OutReady = 1'b0;
    send(1, 16, 'h23, 2, 0, 0, 1, 2);
    InValid = 1'b1;
    Flush = 1'b1;
    idle(1);
    Flush = 1'b0;
    InValid = 1'b0;
    idle(1);
    OutReady = 1'b1;
    send(0, 7, 'h13, 0, 0, 1, 1, 0);
    idle(2);

    // Asynchronous reset while the output slot is full.
    OutReady = 1'b0;
    send(0, 9, 'h13, 0, 0, 2, 2, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outvalid", 32'(OutValid), 32'h0);
    idle(2);
    rst_n = 1'b1;
    OutReady = 1'b1;
    idle(2);

    // Random traffic with random consumer stalls and occasional error clears.
    fork
      begin
        while (!rand_done) begin
          OutReady = ($urandom_range(0, 3) != 0);
          ErrClr = ($urandom_range(0, 15) == 0);
          idle(1);
        end
        OutReady = 1'b1;
        ErrClr = 1'b0;
      end
      begin
        for (int i = 0; i < 250; i++) begin
          int imm;
          if ($urandom_range(0, 3) == 0) imm = int'($urandom);
          else imm = int'($urandom_range(0, 10000)) - 5000;
          send(int'($urandom_range(0, 3)), imm, int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_done = 1'b1;
      end
    join
    idle(5);
    chk("drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
